// File: rtl/carry_select_adder_pipe_pkg.sv
// Shared constants for the carry-select adder family: default operand width
// and the rule that places the low/high split at the midpoint.
package carry_select_adder_pipe_pkg;

  // Default operand width; legal widths are even and at least 4.
  localparam int CSA_N_DEFAULT = 8;

  // Split point between the low (ripple) block and the high (selected) block.
  function automatic int csa_half(input int n);
    return n / 2;
  endfunction

endpackage

// File: rtl/csa_block_add.sv
// W-bit adder block with carry-in and carry-out; the building block of the
// low half and of both speculative high halves.
module csa_block_add #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  // Widen by one bit so the carry falls out of the same addition.
  always_comb begin
    {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  end

endmodule

// File: rtl/multiplexer_2to1.sv
// Single-bit 2-to-1 multiplexer: y = sel ? d1 : d0.
module multiplexer_2to1 (
  input  logic d0,
  input  logic d1,
  input  logic sel,
  output logic y
);

  // Plain select between the two data bits.
  always_comb begin
    y = sel ? d1 : d0;
  end

endmodule

// File: rtl/multiplexer_N_2to1.sv
// N-bit 2-to-1 multiplexer: y = sel ? d1 : d0.
module multiplexer_N_2to1 #(
  parameter int N = 4
) (
  input  logic [N-1:0] d0,
  input  logic [N-1:0] d1,
  input  logic         sel,
  output logic [N-1:0] y
);

  // Plain select between the two data words.
  always_comb begin
    y = sel ? d1 : d0;
  end

endmodule

// File: rtl/carry_select_adder_pipe.sv
// Two-stage pipelined carry-select adder with valid/ready handshakes.
// Stage 1 adds the low half and both speculative high halves (carry-in 0
// and 1); stage 2 uses the low-half carry to pick the high half and carry-out.
// N must be even and at least 4; H must be left at its default of N/2.
module carry_select_adder_pipe
  import carry_select_adder_pipe_pkg::*;
#(
  parameter int N = CSA_N_DEFAULT,
  parameter int H = csa_half(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout
);

  // Stage-1 combinational results
  logic [H-1:0] lo_sum_next;
  logic         lo_carry_next;
  logic [H-1:0] hi_sum_next   [2];
  logic         hi_carry_next [2];

  // Stage-1 registers
  logic [H-1:0] lo_sum_reg;
  logic         c_lo_reg;
  logic [H-1:0] s0_reg;
  logic [H-1:0] s1_reg;
  logic         k0_reg;
  logic         k1_reg;
  logic         s1_valid_reg;

  // Stage-2 selection and registers
  logic [H-1:0] hi_sel;
  logic         cout_sel;
  logic [N-1:0] sum_reg;
  logic         cout_reg;
  logic         out_valid_reg;

  // Handshake / advance control
  logic         load_s2;
  logic         load_s1;

  // Stage 2 may advance when it is empty or its result is being consumed;
  // stage 1 may advance when it is empty or stage 2 is taking its contents.
  always_comb begin
    load_s2  = !out_valid_reg || out_ready;
    load_s1  = !s1_valid_reg || load_s2;
    in_ready = load_s1 || rst;
  end

  // Low block: real carry-in.
  csa_block_add #(.W(H)) u_add_lo (
    .a    (a[H-1:0]),
    .b    (b[H-1:0]),
    .cin  (cin),
    .sum  (lo_sum_next),
    .cout (lo_carry_next)
  );

  // High blocks: index gi is the speculative carry-in (0 then 1).
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_hi
      csa_block_add #(.W(H)) u_add_hi (
        .a    (a[N-1:H]),
        .b    (b[N-1:H]),
        .cin  (1'(gi)),
        .sum  (hi_sum_next[gi]),
        .cout (hi_carry_next[gi])
      );
    end
  endgenerate

  // Stage 1 register: capture low sum/carry and both speculative high results.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
    end else if (load_s1) begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        lo_sum_reg <= lo_sum_next;
        c_lo_reg   <= lo_carry_next;
        s0_reg     <= hi_sum_next[0];
        s1_reg     <= hi_sum_next[1];
        k0_reg     <= hi_carry_next[0];
        k1_reg     <= hi_carry_next[1];
      end
    end
  end

  // The low-half carry chooses which speculative high half is correct.
  multiplexer_N_2to1 #(.N(H)) u_mux_hi (
    .d0  (s0_reg),
    .d1  (s1_reg),
    .sel (c_lo_reg),
    .y   (hi_sel)
  );

  multiplexer_2to1 u_mux_cout (
    .d0  (k0_reg),
    .d1  (k1_reg),
    .sel (c_lo_reg),
    .y   (cout_sel)
  );

  // Stage 2 register: assemble the final sum and carry-out; held under back-pressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      sum_reg       <= '0;
      cout_reg      <= 1'b0;
    end else if (load_s2) begin
      out_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        sum_reg  <= {hi_sel, lo_sum_reg};
        cout_reg <= cout_sel;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign sum       = sum_reg;
  assign cout      = cout_reg;

endmodule

// File: tb/tb_carry_select_adder_pipe.sv
// Self-checking bench for carry_select_adder_pipe: directed cases plus a
// randomized stream, checked by a queue scoreboard against plain arithmetic.
module tb_carry_select_adder_pipe;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic         cin = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         in_ready;
  logic         out_valid;
  logic         cout;
  logic [N-1:0] sum;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int txn = 0;
  bit rand_ready = 1'b0;

  logic [N:0] exp_q [$];
  int         out_cycles [$];

  always #5 clk = ~clk;

  carry_select_adder_pipe #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: the whole N+1-bit sum, cout in the top bit.
  function automatic logic [N:0] model(input logic [N-1:0] x, input logic [N-1:0] y, input logic c);
    int unsigned t;
    t = int'(x) + int'(y) + int'(c);
    return t[N:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: inputs/outputs are stable at the falling edge; what is seen here
  // is what transfers at the next rising edge.
  logic         hold_prev = 1'b0;
  logic [N-1:0] sum_prev;
  logic         cout_prev;
  logic [N:0]   e;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      hold_prev = 1'b0;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL in_ready_in_reset actual=%b required=1", in_ready);
      end
    end else begin
      if (hold_prev) begin
        checks++;
        if (out_valid !== 1'b1 || sum !== sum_prev || cout !== cout_prev) begin
          errors++;
          $display("FAIL hold_stable actual=%b/%0h/%b required=1/%0h/%b",
                   out_valid, sum, cout, sum_prev, cout_prev);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result actual=%0h/%b required=none", sum, cout);
        end else begin
          e = exp_q.pop_front();
          if ({cout, sum} !== e) begin
            errors++;
            $display("FAIL result actual=%0h/%b required=%0h/%b", sum, cout, e[N-1:0], e[N]);
          end
        end
        txn++;
        $display("txn %0d cycle %0d: sum=%02h cout=%b", txn, cyc, sum, cout);
        out_cycles.push_back(cyc);
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, cin));
      hold_prev = out_valid && !out_ready;
      sum_prev  = sum;
      cout_prev = cout;
    end
  end

  // Random back-pressure while enabled.
  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one operand set and return 1 time unit after the accepting edge.
  task automatic send(input logic [N-1:0] x, input logic [N-1:0] y, input logic c);
    bit acc;
    int n;
    n = 0;
    in_valid = 1'b1;
    a = x;
    b = y;
    cin = c;
    forever begin
      @(negedge clk);
      acc = in_ready && !rst;
      @(posedge clk);
      #1;
      if (acc) break;
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout actual=%0d required<=200", n);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_sum", 32'(sum), 32'd0);
    check("reset_cout", 32'(cout), 32'd0);

    // Wrap-around and two-cycle latency.
    send(8'hFF, 8'h01, 1'b0);
    check("latency_not_early", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("latency_on_time", 32'(out_valid), 32'd1);
    check("wrap_sum", 32'(sum), 32'h00);
    check("wrap_cout", 32'(cout), 32'd1);
    idle(3);

    // Low-block carry selects the carry-in-1 high half.
    send(8'h0F, 8'h01, 1'b0);
    @(posedge clk);
    #1;
    check("csel_sum", 32'(sum), 32'h10);
    check("csel_cout", 32'(cout), 32'd0);
    idle(3);

    // Back-to-back stream: results on consecutive cycles.
    out_cycles.delete();
    send(8'h10, 8'h20, 1'b0);
    send(8'h7F, 8'h01, 1'b0);
    send(8'h80, 8'h80, 1'b1);
    idle(5);
    check("stream_count", 32'(out_cycles.size()), 32'd3);
    if (out_cycles.size() == 3) begin
      check("stream_gap1", 32'(out_cycles[1] - out_cycles[0]), 32'd1);
      check("stream_gap2", 32'(out_cycles[2] - out_cycles[1]), 32'd1);
    end

    // Back-pressure: two accepts fill the pipe, then in_ready drops.
    out_cycles.delete();
    out_ready = 1'b0;
    fork
      begin
        send(8'h11, 8'h22, 1'b0);
        send(8'h33, 8'h44, 1'b1);
        send(8'hF0, 8'h20, 1'b0);
      end
      begin
        repeat (2) @(posedge clk);
        #2;
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_first_sum", 32'(sum), 32'h33);
        @(posedge clk);
        #2;
        check("bp_still_low", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
      end
    join
    idle(5);
    check("bp_count", 32'(out_cycles.size()), 32'd3);

    // Reset with two results in flight; the offered operand is ignored.
    out_ready = 1'b0;
    send(8'h01, 8'h02, 1'b0);
    send(8'h03, 8'h04, 1'b0);
    rst = 1'b1;
    in_valid = 1'b1;
    a = 8'h55;
    b = 8'hAA;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    out_ready = 1'b1;
    out_cycles.delete();
    idle(5);
    check("rst_no_stale", 32'(out_cycles.size()), 32'd0);

    // Randomized stream with random back-pressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      send(N'($urandom), N'($urandom), 1'($urandom_range(0, 1)));
    end
    in_valid = 1'b0;
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/carry_select_adder_pipe.md
CARRY_SELECT_ADDER_PIPE -- requirements
Module: carry_select_adder_pipe

Interface
REQ-001 SHALL have parameter N, default 8, operand width; legal values are even integers of 4 or more.
REQ-002 SHALL have parameter H, fixed at N/2, the split point between the low block and the high block.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 in_valid  input  1  operands a, b and cin are presented.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 a  input  N  operand A, unsigned.
REQ-008 b  input  N  operand B, unsigned.
REQ-009 cin  input  1  carry-in.
REQ-010 out_valid  output  1  sum and cout hold a valid result.
REQ-011 out_ready  input  1  downstream consumes the result this cycle.
REQ-012 sum  output  N  (a + b + cin) mod 2^N.
REQ-013 cout  output  1  carry-out, bit N of a + b + cin.

Function
REQ-014 An operand transfer SHALL occur only in a cycle where in_valid and in_ready are both 1; a result transfer SHALL occur only where out_valid and out_ready are both 1.
REQ-015 Stage 1 SHALL register: the low sum a[H-1:0]+b[H-1:0]+cin; its carry c_lo; the high sums s0 (carry-in 0) and s1 (carry-in 1) of a[N-1:H]+b[N-1:H]; their carries k0 and k1; and s1_valid.
REQ-016 Stage 2 SHALL register: sum[N-1:H] = c_lo ? s1 : s0, and sum[H-1:0] = the stage-1 low sum.
REQ-017 Stage 2 SHALL also register cout = c_lo ? k1 : k0, and out_valid.
REQ-018 Latency SHALL be exactly 2 cycles: operands accepted at edge t appear with out_valid=1 after edge t+2, provided out_ready=1 throughout.
REQ-019 Throughput SHALL be one result per cycle with no bubbles when out_ready is held at 1.
REQ-020 Advance rules: stage 2 loads when out_valid=0 or out_ready=1; stage 1 loads when s1_valid=0 or stage 2 loads.
REQ-021 in_ready SHALL equal the stage-1 load condition (combinational from out_ready and internal valids).
REQ-022 Back-pressure: while out_valid=1 and out_ready=0, sum and cout SHALL hold stable; no result SHALL be lost or duplicated.
REQ-023 Simultaneous accept and emit in the same cycle SHALL both complete.
REQ-024 Wrap-around: overflow SHALL wrap modulo 2^N, with cout=1; no saturation.
REQ-025 A stage with valid=0 SHALL hold its data registers unchanged; sum and cout contents are don't-care while out_valid=0.

Reset
REQ-026 When rst=1 at a rising edge, s1_valid and out_valid SHALL clear to 0, and sum and cout SHALL clear to 0.
REQ-027 Reset mid-operation SHALL discard all in-flight operands; the first result after reset SHALL come only from operands accepted after rst deasserts.
REQ-028 During reset, in_ready SHALL be 1, but any transfer in a reset cycle SHALL be ignored.

Structure
REQ-029 The high-half select SHALL instantiate multiplexer_N_2to1 with parameter N=H.
REQ-030 The cout select SHALL instantiate the existing single-bit 2-to-1 multiplexer.
REQ-031 N's default and the derivation H=N/2 SHALL live in the shared adders constants header; no other shared typedefs are needed.
REQ-032 One sub-module, csa_block_add (an H-bit adder with sum and carry outputs), SHALL be instantiated three times in stage 1.

Verification
REQ-033 N=8, a=0xFF, b=0x01, cin=0, out_ready=1 -> sum=0x00, cout=1, out_valid high exactly 2 cycles after acceptance.
REQ-034 N=8, a=0x0F, b=0x01, cin=0 -> low-block carry selects s1; sum=0x10, cout=0.
REQ-035 Back-to-back stream of 0x10+0x20, 0x7F+0x01, 0x80+0x80 with cin=1 on the third -> results 0x30/0, 0x80/0, 0x01/1 on consecutive cycles.
REQ-036 Hold out_ready=0 for 3 cycles with 3 operands offered -> in_ready drops after 2 accepts, output stable, all 3 results emerge in order after out_ready=1.
REQ-037 Assert rst for 1 cycle with 2 results in flight -> out_valid=0 next cycle, and no stale result ever appears.
REQ-038 Random check: 1000 random a, b, cin with random out_ready -> every result equals a+b+cin mod 256 with correct cout, in order.
